// File: rtl/s298_resp_misr.sv
// Response MISR for the s298 core: folds the six primary outputs into a
// WIDTH-bit signature over NCYC cycles. Define S298_MISR_COMPARE_EN to build the GOLDEN compare.
module s298_resp_misr #(
  parameter int               WIDTH = 16,
  parameter int               NCYC  = 64,
  parameter logic [WIDTH-1:0] POLY  = 16'h8016,
  parameter logic [WIDTH-1:0] SEED  = 16'hFFFF
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             HOLD,
  input  logic             G66,
  input  logic             G67,
  input  logic             G117,
  input  logic             G118,
  input  logic             G132,
  input  logic             G133,
  input  logic [WIDTH-1:0] GOLDEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SIG,
  output logic             PASS,
  output logic [7:0]       CNT
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_e;

  localparam logic [7:0] NCYC8 = 8'(NCYC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d, resp;
  logic [7:0]       cnt_q, cnt_d;

  assign resp = {{(WIDTH-6){1'b0}}, G67, G66, G133, G132, G118, G117};

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = ARM;
        sig_d   = SEED;
        cnt_d   = 8'd0;
      end
      // ARM swallows the stale response left in the core's output flops
      ARM: state_d = RUN;
      RUN: if (!HOLD) begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp;
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == NCYC8) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef S298_MISR_COMPARE_EN
  logic pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (state_q == IDLE && START) pass_d = 1'b0;
    else if (state_q == FIN)      pass_d = (sig_q == GOLDEN);
  end

  always_ff @(posedge CK) begin
    if (!RN) pass_q <= 1'b0;
    else     pass_q <= pass_d;
  end

  assign PASS = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign PASS = 1'b0;
`endif

  assign BUSY = (state_q == ARM) || (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign SIG  = sig_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_s298_resp_misr.sv
// Bench for s298_resp_misr: six instances with different NCYC/SEED share one
// stimulus stream; a run-level model is compared every cycle, plus literal pins.
module tb_s298_resp_misr;
  localparam int N = 6;
  localparam logic [N-1:0][7:0]  NCV  = {8'd13, 8'd8, 8'd1, 8'd2, 8'd1, 8'd4};
  localparam logic [N-1:0][15:0] SDV  = {16'hACE1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0]        POLY = 16'h8016;
`ifdef S298_MISR_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic CK = 1'b0, RN = 1'b0, START = 1'b0, HOLD = 1'b0;
  logic [5:0]  r = 6'd0;
  logic [15:0] GOLDEN = 16'd0;
  logic [N-1:0]       busy_w, done_w, pass_w;
  logic [N-1:0][15:0] sig_w;
  logic [N-1:0][7:0]  cnt_w;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 CK = ~CK;

  for (genvar i = 0; i < N; i++) begin : g_dut
    s298_resp_misr #(.WIDTH(16), .NCYC(int'(NCV[i])), .POLY(POLY), .SEED(SDV[i])) u (
      .CK(CK), .RN(RN), .START(START), .HOLD(HOLD),
      .G66(r[4]), .G67(r[5]), .G117(r[0]), .G118(r[1]), .G132(r[2]), .G133(r[3]),
      .GOLDEN(GOLDEN), .BUSY(busy_w[i]), .DONE(done_w[i]), .SIG(sig_w[i]),
      .PASS(pass_w[i]), .CNT(cnt_w[i]));
  end

  // Run-level model: phase 0 idle, 1 arm, 2 compacting, 3 finished
  int          mphase[N];
  logic [15:0] msig[N];
  int          mcnt[N];
  bit          mpass[N];

  always @(posedge CK) begin
    for (int i = 0; i < N; i++) begin
      int ph, c;
      logic [15:0] s;
      bit p;
      ph = mphase[i]; s = msig[i]; c = mcnt[i]; p = mpass[i];
      if (!RN) begin
        ph = 0; s = SDV[i]; c = 0; p = 0;
      end else if (ph == 0) begin
        if (START) begin ph = 1; s = SDV[i]; c = 0; p = 0; end
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2) begin
        if (!HOLD) begin
          s = (s << 1) ^ (msig[i][15] ? POLY : 16'h0) ^ {10'd0, r};
          c = c + 1;
          if (c == int'(NCV[i])) ph = 3;
        end
      end else begin
        p = CMP && (s == GOLDEN);
        ph = 0;
      end
      mphase[i] <= ph; msig[i] <= s; mcnt[i] <= c; mpass[i] <= p;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  always @(negedge CK) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk("busy", i, 32'(busy_w[i]), 32'(mphase[i] == 1 || mphase[i] == 2));
        chk("done", i, 32'(done_w[i]), 32'(mphase[i] == 3));
        chk("sig",  i, 32'(sig_w[i]),  32'(msig[i]));
        chk("cnt",  i, 32'(cnt_w[i]),  32'(mcnt[i]));
        chk("pass", i, 32'(pass_w[i]), 32'(mpass[i]));
      end
    end
  end

  task automatic tick();
    @(posedge CK); #1;
  endtask

  task automatic go();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  initial begin
    RN = 1'b0; tick(); chk_en = 1'b1; tick();
    chk("rst_sig", 5, 32'(sig_w[5]), 32'h0000ACE1);
    chk("rst_busy", 5, 32'(busy_w[5]), 32'd0);
    RN = 1'b1;

    // Zero responses: DONE on u0 exactly 6 cycles after START
    r = 6'd0; GOLDEN = 16'h0; go();
    repeat (4) tick();
    chk("zero_done_early", 0, 32'(done_w[0]), 32'd0);
    tick();
    chk("zero_done", 0, 32'(done_w[0]), 32'd1);
    chk("zero_sig", 0, 32'(sig_w[0]), 32'h0);
    chk("zero_cnt", 0, 32'(cnt_w[0]), 32'd4);
    chk("fb_sig", 3, 32'(sig_w[3]), 32'h8016);

    // Single response on u1; u2 sees 000001 then 000000
    repeat (20) tick();
    GOLDEN = 16'h0001; go(); tick();
    r = 6'b000001; tick(); r = 6'd0;
    chk("one_done", 1, 32'(done_w[1]), 32'd1);
    chk("one_sig", 1, 32'(sig_w[1]), 32'h0001);
    tick();
    chk("one_pass", 1, 32'(pass_w[1]), 32'(CMP));
    chk("shift_sig", 2, 32'(sig_w[2]), 32'h0002);
    chk("shift_done", 2, 32'(done_w[2]), 32'd1);
    repeat (20) tick();
    GOLDEN = 16'h0002; go(); tick();
    r = 6'b000001; tick(); r = 6'd0; tick();
    chk("one_nopass", 1, 32'(pass_w[1]), 32'd0);
    tick();
    chk("shift_pass", 2, 32'(pass_w[2]), 32'(CMP));

    // Shift through the top response bit
    repeat (20) tick();
    go(); tick();
    r = 6'b100000; tick();
    r = 6'b000001; tick(); r = 6'd0;
    chk("shift2_sig", 2, 32'(sig_w[2]), 32'h0041);
    chk("shift2_done", 2, 32'(done_w[2]), 32'd1);

    // Stall with junk responses, START ignored while running
    repeat (20) tick();
    go(); tick();
    HOLD = 1'b1; r = 6'h3F; START = 1'b1;
    repeat (3) tick();
    HOLD = 1'b0; r = 6'd0; START = 1'b0;
    chk("stall_done_early", 1, 32'(done_w[1]), 32'd0);
    tick();
    chk("stall_done", 1, 32'(done_w[1]), 32'd1);
    chk("stall_sig", 1, 32'(sig_w[1]), 32'h0);
    chk("stall_cnt", 1, 32'(cnt_w[1]), 32'd1);

    // Reset mid-run on u4 at CNT=3
    repeat (20) tick();
    go(); repeat (4) tick();
    chk("mid_cnt", 4, 32'(cnt_w[4]), 32'd3);
    RN = 1'b0; tick(); RN = 1'b1;
    chk("rst_busy", 4, 32'(busy_w[4]), 32'd0);
    chk("rst_cnt", 4, 32'(cnt_w[4]), 32'd0);
    chk("rst_sig", 4, 32'(sig_w[4]), 32'h0);
    tick();
    chk("rst_nodone", 4, 32'(done_w[4]), 32'd0);

    // Randomized traffic; GOLDEN often tracks u5's signature to hit PASS=1
    repeat (3000) begin
      START  = ($urandom_range(0, 2) == 0);
      HOLD   = ($urandom_range(0, 3) == 0);
      r      = 6'($urandom);
      RN     = ($urandom_range(0, 199) != 0);
      GOLDEN = ($urandom_range(0, 1) == 1) ? msig[5] : 16'($urandom);
      tick();
    end
    RN = 1'b1; START = 1'b0; HOLD = 1'b0;
    repeat (30) tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/s298_resp_misr.md
# s298_resp_misr

Response compactor that sits directly downstream of the s298 core. It consumes the core's six primary outputs every clock and folds them into a multiple-input signature register (MISR) over a programmed window of cycles. It then reports the signature and, optionally, a pass/fail against a golden value. It is the observation half of the s298 self-test harness and runs on the same clock as the core.

## Interface
Parameters:
- WIDTH, 16, signature width; must be ≥ 6.
- NCYC, 64, number of compacted cycles per run; range 1..255.
- POLY, 16'h8016, feedback tap mask, WIDTH bits wide.
- SEED, 16'hFFFF, signature value loaded at reset and at each run start.

Ports (clock and reset first):
- CK, input, 1, clock. Shared with the s298 flops; all state updates on the rising edge.
- RN, input, 1, reset. Synchronous, active-low.
- START, input, 1, run request. Sampled only in IDLE.
- HOLD, input, 1, stall. While high in RUN, there is no compaction and no count.
- G66, G67, G117, G118, G132, G133, input, 1 each, s298 responses.
- GOLDEN, input, WIDTH, expected signature.
- BUSY, output, 1, high in ARM and RUN.
- DONE, output, 1, one-cycle completion pulse.
- SIG, output, WIDTH, current signature register.
- PASS, output, 1, result of the signature compare.
- CNT, output, 8, compacted-cycle count of the current or last run.

## Operation
- FSM states: IDLE, ARM, RUN, FIN.
- IDLE:
  - START=1 → ARM.
  - On the same edge, SIG←SEED, CNT←0 and PASS←0.
  - START=0 → stay in IDLE; SIG, CNT and PASS hold.
- ARM: one cycle, unconditional → RUN. This cycle discards the single stale response cycle caused by the s298 output flops. There is no compaction in ARM.
- RUN, when HOLD=0:
  - R = {G67, G66, G133, G132, G118, G117}, zero-extended to WIDTH bits; G117 is bit 0.
  - SIG ← ({SIG[WIDTH-2:0], 1'b0} ^ (SIG[WIDTH-1] ? POLY : 0)) ^ R.
  - CNT ← CNT+1.
  - When the new CNT equals NCYC → FIN.
- RUN, when HOLD=1: SIG and CNT hold; stay in RUN.
- FIN: one cycle.
  - DONE=1.
  - PASS is registered as (SIG==GOLDEN), using the final SIG.
  - → IDLE.
- START outside IDLE is ignored; there is no queuing.
- GOLDEN is sampled only in FIN.
- Arithmetic: CNT is 8-bit and never wraps, because NCYC ≤ 255. All XORs are over WIDTH bits, and POLY bits above WIDTH-1 are truncated.

## Timing
- Reset (RN=0 at an edge): state=IDLE, SIG=SEED, CNT=0, PASS=0, BUSY=0, DONE=0. Reset takes priority over every other event, including mid-run and in FIN.
- START high at edge t: BUSY=1 from t+1. ARM occupies cycle t+1. The first compaction happens at edge t+2, using responses present in cycle t+1→t+2.
- With HOLD=0 throughout: the last compaction is at edge t+1+NCYC. DONE is high during cycle t+2+NCYC. BUSY is low from that same cycle.
- Each HOLD cycle in RUN adds exactly one cycle of latency.
- PASS becomes valid in the cycle after DONE and holds until the next START or reset.
- SIG and CNT remain stable after FIN until the next START.
- Back-to-back runs: if START is high in the first IDLE cycle after FIN, the new run begins with no gap.

## Configuration
- S298_MISR_COMPARE_EN defined: the GOLDEN compare logic is built, and PASS is registered as described above.
- S298_MISR_COMPARE_EN undefined:
  - The compare logic is removed, GOLDEN is ignored, and PASS is constant 0.
  - The FSM, DONE timing and SIG are unchanged.

## Test plan
All scenarios use SEED=0, WIDTH=16, POLY=16'h8016, with S298_MISR_COMPARE_EN defined unless stated.
- Zero responses: NCYC=4, all G* held at 0, START pulsed → DONE 6 cycles after START; SIG=16'h0000; CNT=4.
- Single response: NCYC=1, G117=1 during the RUN cycle → SIG=16'h0001. With GOLDEN=16'h0001, PASS=1; with GOLDEN=16'h0002, PASS=0.
- Shift: NCYC=2, responses 6'b000001 then 6'b000000 → SIG=16'h0002. NCYC=2, responses 6'b100000 then 6'b000001 → SIG=16'h0041.
- Feedback: SEED=16'h8000, NCYC=1, R=0 → SIG=16'h8016.
- Stall and ignore: NCYC=1, HOLD=1 for 3 RUN cycles with R=6'h3F, then HOLD=0 with R=0 → SIG=16'h0000 and DONE delayed 3 cycles. A START pulse during RUN has no effect.
- Reset mid-run: NCYC=8, RN=0 at CNT=3 → next cycle IDLE, SIG=SEED, CNT=0, BUSY=0, no DONE. With the macro undefined, PASS stays 0 in every scenario.
